// File: rtl/serial_frame_receiver_pkg.sv
// Shared frame-format definitions for the sen/sd serial link.
// The bank-1 serializer uses the same constants, so both ends always agree
// on frame length and on where the address and data fields sit.
package serial_frame_receiver_pkg;

   // Total bits per frame: 5-bit address followed by 8-bit data, MSB first
   localparam int FRAME_BITS = 13;

   // Field positions inside the assembled shift register
   localparam int ADDR_MSB   = 12;
   localparam int ADDR_LSB   = 8;
   localparam int DATA_MSB   = 7;
   localparam int DATA_LSB   = 0;

   // Bit counter width; it saturates at FRAME_BITS+1 so that overlong frames
   // never wrap back around to a valid-looking length
   localparam int CNT_W      = 4;
   localparam int CNT_MAX    = FRAME_BITS + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      WRITE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_frame_receiver_frame_deser.sv
// frame_deser: shift register plus saturating bit counter.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_shift_en      shift i_sd into the LSB and advance the counter
//   i_clear         restart the count; together with i_shift_en the shifted
//                   bit becomes bit 1 of a new frame (count = 1)
//   i_sd            serial data bit
//   o_shreg         assembled frame bits, most recent bit in the LSB
//   o_bit_cnt       number of bits shifted in since the last clear
module frame_deser
   import serial_frame_receiver_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_shift_en,
   input  logic                  i_clear,
   input  logic                  i_sd,
   output logic [FRAME_BITS-1:0] o_shreg,
   output logic [CNT_W-1:0]      o_bit_cnt
);

   logic [FRAME_BITS-1:0] r_shreg;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [CNT_W-1:0]      w_cnt_inc;

   // Saturate so a merged/overlong frame can never count back to FRAME_BITS
   assign w_cnt_inc = (r_bit_cnt == CNT_W'(CNT_MAX)) ? r_bit_cnt : r_bit_cnt + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shreg   <= '0;
         r_bit_cnt <= '0;
      end else if (i_shift_en) begin
         r_shreg   <= {r_shreg[FRAME_BITS-2:0], i_sd};
         r_bit_cnt <= i_clear ? CNT_W'(1) : w_cnt_inc;
      end else if (i_clear) begin
         r_bit_cnt <= '0;
      end
   end

   assign o_shreg   = r_shreg;
   assign o_bit_cnt = r_bit_cnt;

endmodule

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: far-end receiver for the sen/sd serial link.
// Deserializes 13-bit frames (address then data, MSB first) into single-cycle
// writes on register bank 2, counts good frames and flags framing errors.
// Ports:
//   clk        clock, all state on posedge
//   rst        asynchronous active-low reset
//   sen        frame enable, low = bit valid on sd
//   sd         serial data, sampled while sen==0
//   RB2_RW     0 = one-cycle write strobe, 1 otherwise
//   RB2_A      write address, holds last written value
//   RB2_D      write data, holds last written value
//   frame_err  one-cycle pulse when a frame ends with the wrong length
//   frame_cnt  good frames written, saturates at NUM_FRAMES
//   done       sticky once NUM_FRAMES good frames have been written
module serial_frame_receiver
   import serial_frame_receiver_pkg::*;
#(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 8,
   parameter int NUM_FRAMES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sen,
   input  logic              sd,
   output logic              RB2_RW,
   output logic [ADDR_W-1:0] RB2_A,
   output logic [DATA_W-1:0] RB2_D,
   output logic              frame_err,
   output logic [3:0]        frame_cnt,
   output logic              done
);

   state_e                r_state;
   state_e                w_state_nxt;
   logic                  w_shift_en;
   logic                  w_clear;
   logic                  w_load;
   logic                  w_err;
   logic [FRAME_BITS-1:0] w_shreg;
   logic [CNT_W-1:0]      w_bit_cnt;

   frame_deser u_deser (
      .clk        (clk),
      .rst        (rst),
      .i_shift_en (w_shift_en),
      .i_clear    (w_clear),
      .i_sd       (sd),
      .o_shreg    (w_shreg),
      .o_bit_cnt  (w_bit_cnt)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_shift_en  = 1'b0;
      w_clear     = 1'b0;
      w_load      = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!sen) begin
               w_shift_en  = 1'b1;
               w_clear     = 1'b1;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (!sen) begin
               w_shift_en = 1'b1;
            end else if (w_bit_cnt == CNT_W'(FRAME_BITS)) begin
               w_load      = 1'b1;
               w_state_nxt = WRITE;
            end else begin
               w_err       = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         WRITE: begin
            // sen low on the exit edge already carries bit 1 of the next frame
            if (!sen) begin
               w_shift_en  = 1'b1;
               w_clear     = 1'b1;
               w_state_nxt = SHIFT;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         RB2_RW    <= 1'b1;
         RB2_A     <= '0;
         RB2_D     <= '0;
         frame_err <= 1'b0;
         frame_cnt <= '0;
         done      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         // Strobe is registered from the load decision so it lines up with A/D
         RB2_RW    <= ~w_load;
         frame_err <= w_err;
         if (w_load) begin
            RB2_A <= w_shreg[ADDR_MSB:ADDR_LSB];
            RB2_D <= w_shreg[DATA_MSB:DATA_LSB];
         end
         if (r_state == WRITE && frame_cnt != 4'(NUM_FRAMES)) begin
            frame_cnt <= frame_cnt + 4'd1;
            if (frame_cnt == 4'(NUM_FRAMES - 1))
               done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_serial_frame_receiver.sv
module tb_serial_frame_receiver;

   logic       clk = 1'b0;
   logic       rst;
   logic       sen;
   logic       sd;
   logic       RB2_RW;
   logic [4:0] RB2_A;
   logic [7:0] RB2_D;
   logic       frame_err;
   logic [3:0] frame_cnt;
   logic       done;

   int total = 0;
   int bad   = 0;

   // Captured write strobes {A,D} and error pulses
   logic [12:0] wq[$];
   int          err_seen = 0;

   serial_frame_receiver #(.ADDR_W(5), .DATA_W(8), .NUM_FRAMES(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .sen       (sen),
      .sd        (sd),
      .RB2_RW    (RB2_RW),
      .RB2_A     (RB2_A),
      .RB2_D     (RB2_D),
      .frame_err (frame_err),
      .frame_cnt (frame_cnt),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (RB2_RW === 1'b0) wq.push_back({RB2_A, RB2_D});
      if (frame_err === 1'b1) err_seen++;
   end

   // Drives n bits MSB first, then raises sen at the following negedge
   task automatic send_frame(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge clk);
         sen = 1'b0;
         sd  = bits[i];
      end
      @(negedge clk);
      sen = 1'b1;
      sd  = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0; sen = 1'b1; sd = 1'b0;
      #1;
      total++; if (RB2_RW !== 1'b1) begin bad++; $display("FAIL reset_rw got=%b exp=1", RB2_RW); end
      total++; if (RB2_A !== 5'h00) begin bad++; $display("FAIL reset_a got=%h exp=00", RB2_A); end
      total++; if (RB2_D !== 8'h00) begin bad++; $display("FAIL reset_d got=%h exp=00", RB2_D); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", frame_err); end
      total++; if (frame_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", frame_cnt); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      wq.delete();
      err_seen = 0;
   endtask

   task automatic test_single();
      send_frame({3'b0, 5'h11, 8'hA5}, 13);
      total++; if (RB2_RW !== 1'b1) begin bad++; $display("FAIL single_early_rw got=%b exp=1", RB2_RW); end
      @(negedge clk);
      total++; if (RB2_RW !== 1'b0) begin bad++; $display("FAIL single_rw got=%b exp=0", RB2_RW); end
      total++; if (RB2_A !== 5'h11) begin bad++; $display("FAIL single_a got=%h exp=11", RB2_A); end
      total++; if (RB2_D !== 8'hA5) begin bad++; $display("FAIL single_d got=%h exp=a5", RB2_D); end
      total++; if (frame_cnt !== 4'd0) begin bad++; $display("FAIL single_cnt_in_write got=%0d exp=0", frame_cnt); end
      @(negedge clk);
      total++; if (RB2_RW !== 1'b1) begin bad++; $display("FAIL single_rw_after got=%b exp=1", RB2_RW); end
      total++; if (frame_cnt !== 4'd1) begin bad++; $display("FAIL single_cnt got=%0d exp=1", frame_cnt); end
      total++; if (wq.size() != 1) begin bad++; $display("FAIL single_strobes got=%0d exp=1", wq.size()); end
      total++; if (RB2_A !== 5'h11) begin bad++; $display("FAIL single_a_hold got=%h exp=11", RB2_A); end
      wq.delete();
   endtask

   task automatic test_back_to_back();
      logic [12:0] exp [2];
      exp[0] = {5'h03, 8'h3C};
      exp[1] = {5'h1F, 8'hFF};
      send_frame({3'b0, exp[0]}, 13);
      send_frame({3'b0, exp[1]}, 13);
      repeat (3) @(negedge clk);
      total++; if (wq.size() != 2) begin bad++; $display("FAIL b2b_strobes got=%0d exp=2", wq.size()); end
      for (int i = 0; i < 2; i++) begin
         if (wq.size() > 0) begin
            logic [12:0] got;
            got = wq.pop_front();
            total++; if (got !== exp[i]) begin bad++; $display("FAIL b2b_ad%0d got=%h exp=%h", i, got, exp[i]); end
         end
      end
      total++; if (err_seen != 0) begin bad++; $display("FAIL b2b_err got=%0d exp=0", err_seen); end
      total++; if (frame_cnt !== 4'd3) begin bad++; $display("FAIL b2b_cnt got=%0d exp=3", frame_cnt); end
      wq.delete();
   endtask

   task automatic test_short_frame();
      send_frame(16'h0ABC, 12);
      @(negedge clk);
      total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL short_err_pulse got=%b exp=1", frame_err); end
      total++; if (RB2_RW !== 1'b1) begin bad++; $display("FAIL short_rw got=%b exp=1", RB2_RW); end
      @(negedge clk);
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL short_err_end got=%b exp=0", frame_err); end
      repeat (2) @(negedge clk);
      total++; if (err_seen != 1) begin bad++; $display("FAIL short_err_cycles got=%0d exp=1", err_seen); end
      total++; if (wq.size() != 0) begin bad++; $display("FAIL short_strobes got=%0d exp=0", wq.size()); end
      total++; if (frame_cnt !== 4'd3) begin bad++; $display("FAIL short_cnt got=%0d exp=3", frame_cnt); end
      wq.delete();
      err_seen = 0;
   endtask

   task automatic test_long_frame();
      send_frame({2'b0, 1'b1, 5'h04, 8'h44}, 14);
      send_frame({3'b0, 5'h09, 8'h6E}, 13);
      repeat (3) @(negedge clk);
      total++; if (err_seen != 1) begin bad++; $display("FAIL long_err got=%0d exp=1", err_seen); end
      total++; if (wq.size() != 1) begin bad++; $display("FAIL long_strobes got=%0d exp=1", wq.size()); end
      if (wq.size() > 0) begin
         total++; if (wq[0] !== {5'h09, 8'h6E}) begin bad++; $display("FAIL long_next_ad got=%h exp=%h", wq[0], {5'h09, 8'h6E}); end
      end
      total++; if (frame_cnt !== 4'd4) begin bad++; $display("FAIL long_cnt got=%0d exp=4", frame_cnt); end
      wq.delete();
      err_seen = 0;
   endtask

   task automatic test_done();
      for (int k = 0; k < 8; k++) begin
         logic [4:0] a;
         logic [7:0] d;
         a = 5'(k);
         d = 8'hC0 | 8'(k);
         send_frame({3'b0, a, d}, 13);
         if (k == 6) begin
            total++; if (done !== 1'b0) begin bad++; $display("FAIL done_early got=%b exp=0", done); end
         end
      end
      total++; if (frame_cnt !== 4'd7) begin bad++; $display("FAIL done_cnt7 got=%0d exp=7", frame_cnt); end
      @(negedge clk);
      total++; if (RB2_RW !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL done_in_write got=rw%b/done%b exp=rw0/done0", RB2_RW, done); end
      @(negedge clk);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL done_rise got=%b exp=1", done); end
      total++; if (frame_cnt !== 4'd8) begin bad++; $display("FAIL done_cnt8 got=%0d exp=8", frame_cnt); end
      total++; if (wq.size() != 8) begin bad++; $display("FAIL done_strobes got=%0d exp=8", wq.size()); end
      for (int k = 0; k < 8; k++) begin
         if (wq.size() > 0) begin
            logic [12:0] got;
            logic [12:0] exp;
            got = wq.pop_front();
            exp = {5'(k), 8'hC0 | 8'(k)};
            total++; if (got !== exp) begin bad++; $display("FAIL done_ad%0d got=%h exp=%h", k, got, exp); end
         end
      end
      send_frame({3'b0, 5'h15, 8'h99}, 13);
      repeat (2) @(negedge clk);
      total++; if (wq.size() != 1) begin bad++; $display("FAIL ninth_strobes got=%0d exp=1", wq.size()); end
      total++; if (RB2_A !== 5'h15 || RB2_D !== 8'h99) begin bad++; $display("FAIL ninth_ad got=%h/%h exp=15/99", RB2_A, RB2_D); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL ninth_done got=%b exp=1", done); end
      total++; if (frame_cnt !== 4'd8) begin bad++; $display("FAIL ninth_cnt got=%0d exp=8", frame_cnt); end
      total++; if (err_seen != 0) begin bad++; $display("FAIL done_err got=%0d exp=0", err_seen); end
      wq.delete();
   endtask

   task automatic test_reset_mid_frame();
      logic [12:0] f;
      f = {5'h0A, 8'h5A};
      for (int i = 12; i >= 7; i--) begin
         @(negedge clk);
         sen = 1'b0;
         sd  = f[i];
      end
      @(negedge clk);
      rst = 1'b0; sen = 1'b1; sd = 1'b0;
      #1;
      total++; if (RB2_A !== 5'h00 || RB2_D !== 8'h00) begin bad++; $display("FAIL midrst_ad got=%h/%h exp=00/00", RB2_A, RB2_D); end
      total++; if (frame_cnt !== 4'd0 || done !== 1'b0) begin bad++; $display("FAIL midrst_cnt got=%0d/%b exp=0/0", frame_cnt, done); end
      total++; if (RB2_RW !== 1'b1 || frame_err !== 1'b0) begin bad++; $display("FAIL midrst_rw got=%b/%b exp=1/0", RB2_RW, frame_err); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      wq.delete();
      err_seen = 0;
      send_frame({3'b0, f}, 13);
      repeat (3) @(negedge clk);
      total++; if (wq.size() != 1) begin bad++; $display("FAIL midrst_strobes got=%0d exp=1", wq.size()); end
      if (wq.size() > 0) begin
         total++; if (wq[0] !== f) begin bad++; $display("FAIL midrst_write got=%h exp=%h", wq[0], f); end
      end
      total++; if (err_seen != 0) begin bad++; $display("FAIL midrst_err got=%0d exp=0", err_seen); end
      total++; if (frame_cnt !== 4'd1) begin bad++; $display("FAIL midrst_cnt_after got=%0d exp=1", frame_cnt); end
   endtask

   initial begin
      rst = 1'b0;
      sen = 1'b1;
      sd  = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_short_frame();
      test_long_frame();
      test_reset();
      test_done();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
